// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave: decodes address/data strobes into reads and writes.
// Also provides an ID register, a write counter, a saturating error counter and a side read port.
module spi_reg_bank #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    REG_COUNT      = 64,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 32'h5350_4901,
  parameter logic [DATA_WIDTH-1:0] BAD_READ_VALUE = 32'hDEAD_BEEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RWType,
  input  logic [ADDR_WIDTH-1:0] RXAddr,
  input  logic                  RXAddrValid,
  input  logic [DATA_WIDTH-1:0] RXData,
  input  logic                  RXDataValid,
  output logic [DATA_WIDTH-1:0] TXData,
  output logic                  TXDataValid,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  output logic [DATA_WIDTH-1:0] HostRdData,
  output logic [15:0]           WrCount,
  output logic [7:0]            ErrCount
);
  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ      = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  av_q, dv_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  txv_q, txv_d;
  logic [DATA_WIDTH-1:0] host_q, host_d;
  logic [15:0]           wrcnt_q, wrcnt_d;
  logic [7:0]            errcnt_q, errcnt_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  logic addr_rise, data_rise, wr_en, err_inc;

  assign addr_rise = RXAddrValid & ~av_q;
  assign data_rise = RXDataValid & ~dv_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a < ADDR_WIDTH'(REG_COUNT);
  endfunction

  // Reg 0/1 are synthesized from constants/counters; storage slots 0/1 stay zero.
  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(0))      return ID_VALUE;
    else if (a == ADDR_WIDTH'(1)) return {{(DATA_WIDTH-16){1'b0}}, wrcnt_q};
    else if (in_range(a))         return regs_q[a[IDX_W-1:0]];
    else                          return BAD_READ_VALUE;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    txv_d   = txv_q;
    wr_en   = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE, WAIT_DATA: begin
        // A fresh address edge also aborts a pending write frame.
        if (addr_rise) begin
          addr_d = RXAddr;
          if (!RWType) begin
            state_d = READ;
            tx_d    = rd_word(RXAddr);
            txv_d   = 1'b1;
            err_inc = ~in_range(RXAddr);
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (state_q == WAIT_DATA && data_rise) begin
          state_d = IDLE;
          if (!in_range(addr_q))              err_inc = 1'b1;
          else if (addr_q >= ADDR_WIDTH'(2))  wr_en   = 1'b1;
        end
      end
      READ: begin
        if (!RXAddrValid) begin
          state_d = IDLE;
          tx_d    = '0;
          txv_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    wrcnt_d  = wrcnt_q + {15'd0, wr_en};
    errcnt_d = (err_inc && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
    host_d   = rd_word(HostAddr);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      av_q     <= 1'b0;
      dv_q     <= 1'b0;
      addr_q   <= '0;
      tx_q     <= '0;
      txv_q    <= 1'b0;
      host_q   <= '0;
      wrcnt_q  <= '0;
      errcnt_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      av_q     <= RXAddrValid;
      dv_q     <= RXDataValid;
      addr_q   <= addr_d;
      tx_q     <= tx_d;
      txv_q    <= txv_d;
      host_q   <= host_d;
      wrcnt_q  <= wrcnt_d;
      errcnt_q <= errcnt_d;
      if (wr_en) regs_q[addr_q[IDX_W-1:0]] <= RXData;
    end
  end

  assign TXData      = tx_q;
  assign TXDataValid = txv_q;
  assign HostRdData  = host_q;
  assign WrCount     = wrcnt_q;
  assign ErrCount    = errcnt_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: vector table of SPI frames plus hand-built corner sequences.
module tb_spi_reg_bank;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        RWType = 1'b0;
  logic [15:0] RXAddr = '0;
  logic        RXAddrValid = 1'b0;
  logic [31:0] RXData = '0;
  logic        RXDataValid = 1'b0;
  logic [31:0] TXData;
  logic        TXDataValid;
  logic [15:0] HostAddr = '0;
  logic [31:0] HostRdData;
  logic [15:0] WrCount;
  logic [7:0]  ErrCount;

  int checks = 0;
  int errors = 0;

  spi_reg_bank dut (
    .Clk(Clk), .Rst(Rst), .RWType(RWType), .RXAddr(RXAddr), .RXAddrValid(RXAddrValid),
    .RXData(RXData), .RXDataValid(RXDataValid), .TXData(TXData), .TXDataValid(TXDataValid),
    .HostAddr(HostAddr), .HostRdData(HostRdData), .WrCount(WrCount), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [15:0] exp_wr;
    logic [7:0]  exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_write(input logic [15:0] a, input logic [31:0] d, input int hold);
    @(negedge Clk); RWType = 1'b1; RXAddr = a; RXAddrValid = 1'b1;
    repeat (hold) @(negedge Clk);
    RXData = d; RXDataValid = 1'b1;
    repeat (hold) @(negedge Clk);
    RXAddrValid = 1'b0; RXDataValid = 1'b0;
    @(negedge Clk);
  endtask

  // Checks TXDataValid timing and hold, returns the captured read data.
  task automatic spi_read(input logic [15:0] a, input int hold, output logic [31:0] d);
    @(negedge Clk); RWType = 1'b0; RXAddr = a; RXAddrValid = 1'b1;
    @(negedge Clk);
    chk("txv_rise", {31'd0, TXDataValid}, 32'd1);
    d = TXData;
    repeat (hold) @(negedge Clk);
    chk("tx_held", TXData, d);
    RXAddrValid = 1'b0;
    @(negedge Clk);
    chk("txv_fall", {31'd0, TXDataValid}, 32'd0);
    chk("tx_zero", TXData, 32'd0);
  endtask

  vec_t        vecs [16];
  logic [31:0] rd;

  initial begin
    vecs[0]  = '{1'b0, 16'h0000, 32'h5350_4901, 16'd0, 8'd0};
    vecs[1]  = '{1'b1, 16'h0005, 32'hA5A5_0F0F, 16'd1, 8'd0};
    vecs[2]  = '{1'b0, 16'h0005, 32'hA5A5_0F0F, 16'd1, 8'd0};
    vecs[3]  = '{1'b0, 16'h0001, 32'h0000_0001, 16'd1, 8'd0};
    vecs[4]  = '{1'b1, 16'h0100, 32'h0000_1234, 16'd1, 8'd1};
    vecs[5]  = '{1'b0, 16'h0100, 32'hDEAD_BEEF, 16'd1, 8'd2};
    vecs[6]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 16'd1, 8'd2};
    vecs[7]  = '{1'b0, 16'h0000, 32'h5350_4901, 16'd1, 8'd2};
    vecs[8]  = '{1'b1, 16'h0001, 32'h0000_0077, 16'd1, 8'd2};
    vecs[9]  = '{1'b0, 16'h0001, 32'h0000_0001, 16'd1, 8'd2};
    vecs[10] = '{1'b0, 16'h003F, 32'h0000_0000, 16'd1, 8'd2};
    vecs[11] = '{1'b1, 16'h003F, 32'hCAFE_F00D, 16'd2, 8'd2};
    vecs[12] = '{1'b0, 16'h003F, 32'hCAFE_F00D, 16'd2, 8'd2};
    vecs[13] = '{1'b0, 16'h0040, 32'hDEAD_BEEF, 16'd2, 8'd3};
    vecs[14] = '{1'b1, 16'h0002, 32'h0000_1111, 16'd3, 8'd3};
    vecs[15] = '{1'b0, 16'h0002, 32'h0000_1111, 16'd3, 8'd3};

    repeat (3) @(negedge Clk);
    chk("rst_txv", {31'd0, TXDataValid}, 32'd0);
    chk("rst_tx", TXData, 32'd0);
    chk("rst_host", HostRdData, 32'd0);
    chk("rst_wr", {16'd0, WrCount}, 32'd0);
    chk("rst_err", {24'd0, ErrCount}, 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) spi_write(vecs[i].addr, vecs[i].data, 1);
      else begin
        spi_read(vecs[i].addr, 1, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].data);
      end
      chk($sformatf("vec%0d_wr", i), {16'd0, WrCount}, {16'd0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_err", i), {24'd0, ErrCount}, {24'd0, vecs[i].exp_err});
    end

    // Held strobes must produce a single write.
    spi_write(16'h0007, 32'h0BAD_CAFE, 4);
    chk("hold_wr", {16'd0, WrCount}, 32'd4);
    spi_read(16'h0007, 3, rd);
    chk("hold_rd", rd, 32'h0BAD_CAFE);

    @(negedge Clk); HostAddr = 16'h0005;
    @(negedge Clk); chk("host5", HostRdData, 32'hA5A5_0F0F);
    HostAddr = 16'h0001;
    @(negedge Clk); chk("host1", HostRdData, 32'd4);
    HostAddr = 16'hFFFF;
    @(negedge Clk); chk("host_oor", HostRdData, 32'hDEAD_BEEF);
    chk("host_err", {24'd0, ErrCount}, 32'd3);

    // Write frame to 9 aborted by a read of 9 before data arrives.
    @(negedge Clk); RWType = 1'b1; RXAddr = 16'h0009; RXAddrValid = 1'b1; RXData = 32'h9999_9999;
    @(negedge Clk); RXAddrValid = 1'b0;
    spi_read(16'h0009, 1, rd);
    chk("abort_rd", rd, 32'd0);
    chk("abort_wr", {16'd0, WrCount}, 32'd4);

    // Address and data rising together: data edge is ignored.
    @(negedge Clk); RWType = 1'b1; RXAddr = 16'h000A; RXAddrValid = 1'b1;
    RXData = 32'h5555_5555; RXDataValid = 1'b1;
    repeat (2) @(negedge Clk);
    RXAddrValid = 1'b0; RXDataValid = 1'b0;
    @(negedge Clk);
    chk("simul_wr", {16'd0, WrCount}, 32'd4);
    spi_read(16'h000A, 1, rd);
    chk("simul_rd", rd, 32'd0);

    for (int i = 0; i < 300; i++) spi_write(16'h0200, 32'd0, 1);
    chk("err_sat", {24'd0, ErrCount}, 32'h0000_00FF);
    chk("err_sat_wr", {16'd0, WrCount}, 32'd4);

    // Reset while a read is being presented.
    @(negedge Clk); RWType = 1'b0; RXAddr = 16'h0000; RXAddrValid = 1'b1;
    @(negedge Clk);
    chk("pre_rst_txv", {31'd0, TXDataValid}, 32'd1);
    Rst = 1'b1; RXAddrValid = 1'b0;
    @(negedge Clk);
    chk("mid_rst_txv", {31'd0, TXDataValid}, 32'd0);
    chk("mid_rst_tx", TXData, 32'd0);
    chk("mid_rst_wr", {16'd0, WrCount}, 32'd0);
    chk("mid_rst_err", {24'd0, ErrCount}, 32'd0);
    Rst = 1'b0;
    spi_read(16'h0005, 1, rd);
    chk("post_rst_rd5", rd, 32'd0);
    spi_read(16'h0000, 1, rd);
    chk("post_rst_rd0", rd, 32'h5350_4901);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register-bank back end that sits directly downstream of the SPI slave.
- Consumes the slave's decoded address/data/RW strobes, performs writes into a parameterised register array, and returns read data on the slave's TX port.
- Adds a read-only ID register, a write counter, an out-of-range error counter, and a side read port for on-chip consumers.
- Replaces ad-hoc bench register models with synthesizable RTL.

Parameters:
DATA_WIDTH, 32, data word width; matches SPI slave DATA_WIDTH
ADDR_WIDTH, 16, address width; matches SPI slave ADDR_WIDTH
REG_COUNT, 64, number of implemented registers; addresses 0..REG_COUNT-1 valid
ID_VALUE, 32'h5350_4901, constant returned by register 0
BAD_READ_VALUE, 32'hDEAD_BEEF, returned for out-of-range reads

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
RWType  input  1  from SPI slave; 1 = write, 0 = read; sampled with RXAddrValid
RXAddr  input  ADDR_WIDTH  from SPI slave; frame address
RXAddrValid  input  1  from SPI slave; level, high for >=1 Clk once address received, low between frames
RXData  input  DATA_WIDTH  from SPI slave; write data
RXDataValid  input  1  from SPI slave; level, high for >=1 Clk once write data received
TXData  output  DATA_WIDTH  to SPI slave; read data
TXDataValid  output  1  to SPI slave; read data valid
HostAddr  input  ADDR_WIDTH  side read port address
HostRdData  output  DATA_WIDTH  side read data, 1-cycle registered latency
WrCount  output  16  accepted-write counter (mirror of reg 1)
ErrCount  output  8  out-of-range access counter, saturating

Behaviour:
- Reset: all outputs 0, FSM = IDLE, all registers 0 except reg 0. Reg 0 is hardwired to ID_VALUE. Rst overrides everything in the same edge; a frame in progress is discarded.
- Edge detect: registered copies of RXAddrValid/RXDataValid. A rise is current=1 and prev=0, so a held level triggers exactly one action.
- Register map:
  - reg 0: ID, read-only.
  - reg 1: WrCount, read-only; zero-extended to DATA_WIDTH.
  - regs 2..REG_COUNT-1: RW.
  - Writes to 0 or 1 are silently ignored: not counted, not an error.
- FSM states: IDLE, READ, WAIT_DATA.
- IDLE:
  - On RXAddrValid rise, latch RXAddr and RWType.
  - RWType=0 -> READ.
  - RWType=1 -> WAIT_DATA.
- READ:
  - On entry edge, TXData <= reg[addr], or BAD_READ_VALUE if addr >= REG_COUNT (ErrCount++). TXDataValid <= 1.
  - TXDataValid therefore goes high exactly one Clk after the cycle the RXAddrValid rise is sampled.
  - TXData/TXDataValid are held while RXAddrValid=1.
  - When RXAddrValid=0: TXData <= 0, TXDataValid <= 0, -> IDLE.
- WAIT_DATA:
  - On RXDataValid rise, write RXData to the latched addr. If addr in 2..REG_COUNT-1, the write lands and WrCount++ (wraps 16'hFFFF->0). If addr >= REG_COUNT, the write is dropped and ErrCount++. Then -> IDLE.
  - If RXAddrValid falls, then rises again before any RXDataValid rise, the frame is aborted. The new address/RWType is latched and handled as from IDLE. No write, no count.
- Simultaneous events:
  - RXAddrValid rise and RXDataValid rise in the same cycle while in IDLE: address is processed first; the data edge is ignored (data must follow address).
  - Side-port read of a register being written in the same cycle returns the old value (read-before-write).
  - Reading reg 1 in the same cycle as a write increment returns the pre-increment value.
- ErrCount saturates at 8'hFF.
- HostRdData: registered read of reg[HostAddr]; BAD_READ_VALUE if out of range; does not touch ErrCount. Independent of the FSM.
- TXData is 0 whenever TXDataValid=0.

Test Plan:
- Reset then SPI read addr 0 -> TXDataValid high 1 Clk after RXAddrValid rise, TXData=32'h53504901; TXDataValid drops the cycle after RXAddrValid falls; TXData returns to 0.
- Write addr 5 data 32'hA5A5_0F0F, then read addr 5 -> TXData=32'hA5A50F0F; WrCount=1; HostAddr=5 gives HostRdData=32'hA5A50F0F next cycle.
- RXAddrValid/RXDataValid held high 4 Clk each on a write to addr 7 -> exactly one write; WrCount increments by 1 only.
- Write addr 16'h0100 (>= 64) data 32'h1234 -> no register changes, ErrCount=1; read addr 16'h0100 -> TXData=32'hDEADBEEF, ErrCount=2.
- Write addr 0 data 32'hFFFF_FFFF -> read addr 0 still 32'h53504901; WrCount and ErrCount unchanged.
- Write frame to addr 9 aborted (second RXAddrValid rise, read addr 9, before RXDataValid) -> addr 9 unchanged (0), read completes normally; Rst pulsed mid-READ -> TXDataValid=0 and FSM in IDLE next cycle.
